param_counter: RTL and testbench

PARAM_COUNTER -- requirements
Module: param_counter

---
 rtl/param_counter.sv | 98 +++++++++
 tb/tb_param_counter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/param_counter.sv
// Parameterised up/down counter with wrap, saturate and one-shot modes,
// a registered terminal-count pulse and a sticky overflow flag.
module param_counter #(
  parameter int WIDTH = 8,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] term_val;
  logic             tc_d;
  logic             ovf_set;
  logic             at_term;
  logic             wrap_mode;
  logic             one_shot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next count; load always wins over counting and never pulses tc.
  // Counting up, anything at or above limit is terminal so a lowered limit takes hold at once.
  always_comb begin
    state_d   = state_q;
    out_d     = out;
    tc_d      = 1'b0;
    ovf_set   = 1'b0;
    wrap_mode = (mode == 2'b00) || (mode == 2'b11);
    one_shot  = (mode == 2'b10);
    term_val  = up ? limit : ZERO;
    at_term   = up ? (out >= limit) : (out == ZERO);
    step_val  = up ? (out + ONE) : (out - ONE);
    if (load) begin
      out_d   = (data > limit) ? limit : data;
      state_d = RUN;
    end else if (state_q == RUN && en) begin
      if (at_term) begin
        ovf_set = 1'b1;
        if (wrap_mode) begin
          out_d = up ? ZERO : limit;
          tc_d  = 1'b1;
        end else begin
          out_d = term_val;
          if (one_shot) state_d = DONE;
        end
      end else begin
        out_d = step_val;
        if (!wrap_mode && step_val == term_val) begin
          tc_d = 1'b1;
          if (one_shot) state_d = DONE;
        end
      end
    end
  end

  // Sticky overflow: a new event on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= WIDTH'(RESET_VAL);
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      out <= out_d;
      tc  <= tc_d;
      ovf <= ovf_set | (ovf & ~clr_ovf);
    end
  end

  always_comb begin
    busy = (state_q == RUN);
  end

endmodule

// File: tb/tb_param_counter.sv
// Self-checking bench for param_counter: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_param_counter;

  localparam int WIDTH = 8;
  localparam int MODULUS = 1 << WIDTH;
  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             up;
  logic [1:0]       mode;
  logic [WIDTH-1:0] limit;
  logic             clrOvf;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             ovf;
  logic             busy;

  int testsRun = 0;
  int testsFailed = 0;

  int mOut;
  int mTc;
  int mOvf;
  int mPhase;

  param_counter #(.WIDTH(WIDTH), .RESET_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .up(up),
    .mode(mode), .limit(limit), .clr_ovf(clrOvf),
    .out(out), .tc(tc), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mOut = 0;
    mTc = 0;
    mOvf = 0;
    mPhase = PH_IDLE;
  endtask

  // Behavioural rules of the counter, evaluated on the inputs presented before an edge.
  task automatic modelStep();
    int lim = int'(limit);
    int term;
    bit wrapMode;
    bit pastTerm;
    bit setOvf = 0;
    mTc = 0;
    wrapMode = (mode == 2'd0) || (mode == 2'd3);
    term = up ? lim : 0;
    if (load) begin
      mOut = (int'(data) < lim) ? int'(data) : lim;
      mPhase = PH_RUN;
    end else if (mPhase == PH_RUN && en) begin
      pastTerm = up ? (mOut >= lim) : (mOut == 0);
      if (pastTerm) begin
        setOvf = 1;
        if (wrapMode) begin
          mOut = up ? 0 : lim;
          mTc = 1;
        end else begin
          mOut = term;
          if (mode == 2'd2) mPhase = PH_DONE;
        end
      end else begin
        mOut = (mOut + (up ? 1 : -1) + MODULUS) % MODULUS;
        if (!wrapMode && mOut == term) begin
          mTc = 1;
          if (mode == 2'd2) mPhase = PH_DONE;
        end
      end
    end
    mOvf = (setOvf || (mOvf && !clrOvf)) ? 1 : 0;
  endtask

  task automatic checkModel();
    checkOutput("model_out", 32'(out), 32'(mOut));
    checkOutput("model_tc", 32'(tc), 32'(mTc));
    checkOutput("model_ovf", 32'(ovf), 32'(mOvf));
    checkOutput("model_busy", 32'(busy), (mPhase == PH_RUN) ? 32'd1 : 32'd0);
  endtask

  task automatic applyStimulus(input logic ld, input logic [WIDTH-1:0] d, input logic e,
                               input logic u, input logic [1:0] m, input logic [WIDTH-1:0] lim,
                               input logic clr);
    load = ld;
    data = d;
    en = e;
    up = u;
    mode = m;
    limit = lim;
    clrOvf = clr;
    modelStep();
    @(posedge clk);
    #1;
    checkModel();
  endtask

  initial begin
    logic [7:0] wrapOut [4];
    logic [7:0] satOut [3];
    wrapOut = '{8'h04, 8'h05, 8'h00, 8'h01};
    satOut  = '{8'h01, 8'h00, 8'h00};

    rst = 1'b0;
    en = 1'b0; load = 1'b0; data = '0; up = 1'b1; mode = 2'b00; limit = '0; clrOvf = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out", 32'(out), 32'h00);
    checkOutput("reset_tc", 32'(tc), 32'h0);
    checkOutput("reset_ovf", 32'(ovf), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    rst = 1'b1;

    // Wrap up through limit 5
    applyStimulus(1'b1, 8'h03, 1'b1, 1'b1, 2'b00, 8'h05, 1'b0);
    checkOutput("wrap_load", 32'(out), 32'h03);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 8'h05, 1'b0);
      checkOutput("wrap_out", 32'(out), 32'(wrapOut[i]));
      checkOutput("wrap_tc", 32'(tc), (i == 2) ? 32'd1 : 32'd0);
      checkOutput("wrap_ovf", 32'(ovf), (i >= 2) ? 32'd1 : 32'd0);
    end

    // Saturate down, then clear the sticky flag
    applyStimulus(1'b1, 8'h02, 1'b1, 1'b0, 2'b01, 8'h05, 1'b1);
    checkOutput("sat_load", 32'(out), 32'h02);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 2'b01, 8'h05, 1'b0);
      checkOutput("sat_out", 32'(out), 32'(satOut[i]));
      checkOutput("sat_tc", 32'(tc), (i == 1) ? 32'd1 : 32'd0);
      checkOutput("sat_ovf", 32'(ovf), (i == 2) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 8'h05, 1'b1);
    checkOutput("sat_clr_ovf", 32'(ovf), 32'h0);

    // One-shot up to 0xFF, hold, then reload
    applyStimulus(1'b1, 8'hFC, 1'b1, 1'b1, 2'b10, 8'hFF, 1'b0);
    checkOutput("os_load", 32'(out), 32'hFC);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 2'b10, 8'hFF, 1'b0);
      checkOutput("os_out", 32'(out), 32'hFD + 32'(i));
      checkOutput("os_tc", 32'(tc), (i == 2) ? 32'd1 : 32'd0);
      checkOutput("os_busy", 32'(busy), (i == 2) ? 32'd0 : 32'd1);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 2'b10, 8'hFF, 1'b0);
      checkOutput("os_hold", 32'(out), 32'hFF);
    end
    applyStimulus(1'b1, 8'h10, 1'b1, 1'b1, 2'b10, 8'hFF, 1'b0);
    checkOutput("os_reload_busy", 32'(busy), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 2'b10, 8'hFF, 1'b0);
    checkOutput("os_recount", 32'(out), 32'h11);

    // Load clamps to limit
    applyStimulus(1'b1, 8'h6C, 1'b0, 1'b1, 2'b00, 8'h50, 1'b0);
    checkOutput("clamp_out", 32'(out), 32'h50);
    checkOutput("clamp_tc", 32'(tc), 32'h0);

    // Asynchronous reset mid-count
    applyStimulus(1'b1, 8'h30, 1'b1, 1'b1, 2'b00, 8'hFF, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 8'hFF, 1'b0);
    checkOutput("areset_pre", 32'(out), 32'h37);
    #2;
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput("areset_out", 32'(out), 32'h00);
    checkOutput("areset_tc", 32'(tc), 32'h0);
    checkOutput("areset_ovf", 32'(ovf), 32'h0);
    checkOutput("areset_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 8'hFF, 1'b0);
      checkOutput("areset_idle", 32'(out), 32'h00);
    end

    // Randomized traffic
    limit = 8'($urandom_range(0, 255));
    for (int i = 0; i < 600; i++) begin
      logic [WIDTH-1:0] nextLimit;
      nextLimit = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : limit;
      applyStimulus(($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)),
                    ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), nextLimit, ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
